// File: rtl/icache_nway_lru_if.sv
// Fetch-side and refill-side signal bundle for icache_nway_lru.
// master = processor/RAM environment, slave = the cache.
interface icache_nway_lru_if #(
   parameter int ADDR_W = 32,
   parameter int WPL    = 2
);
   logic              proc_req;
   logic [ADDR_W-1:0] address_from_proc;
   logic              flush;
   logic [31:0]       data_to_proc;
   logic              proc_resp_valid;
   logic              hit_miss;
   logic              busy;
   logic              ram_req;
   logic [ADDR_W-1:0] address_to_ram;
   logic [32*WPL-1:0] data_from_ram;
   logic              ram_access_done;

   modport master (
      output proc_req, address_from_proc, flush, data_from_ram, ram_access_done,
      input  data_to_proc, proc_resp_valid, hit_miss, busy, ram_req, address_to_ram
   );

   modport slave (
      input  proc_req, address_from_proc, flush, data_from_ram, ram_access_done,
      output data_to_proc, proc_resp_valid, hit_miss, busy, ram_req, address_to_ram
   );
endinterface

// File: rtl/icache_nway_lru.sv
// N-way set-associative read-only instruction cache with true LRU (per-set age
// counters), line refill handshake and flush-all.

// One way of the addressed set: tag compare and its next LRU age.
module icache_lru_way #(
   parameter int TAG_W = 27,
   parameter int AGE_W = 2
) (
   input  logic             valid,
   input  logic [TAG_W-1:0] tag,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [AGE_W-1:0] age,
   input  logic [AGE_W-1:0] acc_age,
   input  logic             acc_sel,
   output logic             hit,
   output logic [AGE_W-1:0] age_nxt
);
   assign hit = valid && (tag == req_tag);

   // Ways younger than the accessed one age by one; the accessed way becomes MRU.
   always_comb begin
      age_nxt = age;
      if (acc_sel)
         age_nxt = '0;
      else if (age < acc_age)
         age_nxt = age + AGE_W'(1);
   end
endmodule

module icache_nway_lru #(
   parameter int ADDR_W = 32,
   parameter int WAYS   = 4,
   parameter int SETS   = 4,
   parameter int WPL    = 2
) (
   input  logic               clk,
   input  logic               reset,
   icache_nway_lru_if.slave   bus
);
   localparam int WSEL_W = $clog2(WPL);
   localparam int OFF    = WSEL_W + 2;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - OFF - IDX_W;
   localparam int AGE_W  = $clog2(WAYS);
   localparam int WAY_W  = AGE_W;

   typedef enum logic [1:0] {IDLE, LOOKUP, REFILL} state_t;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [IDX_W-1:0]  idx;
      logic [WSEL_W-1:0] word;
   } req_t;

   typedef logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_arr_t;

   function automatic age_arr_t age_init();
      age_arr_t a;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++)
            a[s][w] = AGE_W'(w);
      return a;
   endfunction

   state_t state_q, state_d;
   req_t   req_q;

   logic [SETS-1:0][WAYS-1:0]                  valid_q;
   logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]       tag_q;
   logic [SETS-1:0][WAYS-1:0][WPL-1:0][31:0]   line_q;
   age_arr_t                                   age_q;

   logic [WAY_W-1:0] victim_q;
   logic             flush_pend_q;
   logic [31:0]      data_q;
   logic             resp_q;
   logic             hit_miss_q;
   logic             ram_req_q;
   logic [ADDR_W-1:0] ram_addr_q;

   logic [WAYS-1:0]             way_hit;
   logic [WAYS-1:0][AGE_W-1:0]  age_nxt;
   logic                        any_hit;
   logic [WAY_W-1:0]            hit_way;
   logic [WAY_W-1:0]            victim;
   logic [WAY_W-1:0]            acc_way;
   logic [AGE_W-1:0]            acc_age;
   logic [WPL-1:0][31:0]        ram_words;
   logic                        flush_now;
   logic                        unused_byte_bits;

   assign ram_words        = bus.data_from_ram;
   assign flush_now        = flush_pend_q || bus.flush;
   assign unused_byte_bits = ^bus.address_from_proc[1:0];

   // In LOOKUP the accessed way is the hit way; in REFILL it is the victim.
   assign acc_way = (state_q == LOOKUP) ? hit_way : victim_q;
   assign acc_age = age_q[req_q.idx][acc_way];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      icache_lru_way #(.TAG_W(TAG_W), .AGE_W(AGE_W)) u_way (
         .valid   (valid_q[req_q.idx][w]),
         .tag     (tag_q[req_q.idx][w]),
         .req_tag (req_q.tag),
         .age     (age_q[req_q.idx][w]),
         .acc_age (acc_age),
         .acc_sel (acc_way == WAY_W'(w)),
         .hit     (way_hit[w]),
         .age_nxt (age_nxt[w])
      );
   end

   assign any_hit = |way_hit;

   always_comb begin
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (way_hit[w]) hit_way = WAY_W'(w);
   end

   // Oldest way first, then overridden by the lowest-index invalid way if any.
   always_comb begin
      victim = '0;
      for (int w = 0; w < WAYS; w++)
         if (age_q[req_q.idx][w] == AGE_W'(WAYS - 1)) victim = WAY_W'(w);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_q[req_q.idx][w]) victim = WAY_W'(w);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!flush_now && bus.proc_req) state_d = LOOKUP;
         LOOKUP:  state_d = any_hit ? IDLE : REFILL;
         REFILL:  if (bus.ram_access_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         req_q        <= '0;
         valid_q      <= '0;
         age_q        <= age_init();
         victim_q     <= '0;
         flush_pend_q <= 1'b0;
         data_q       <= '0;
         resp_q       <= 1'b0;
         hit_miss_q   <= 1'b1;
         ram_req_q    <= 1'b0;
         ram_addr_q   <= '0;
      end else begin
         resp_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush_now) begin
                  valid_q      <= '0;
                  age_q        <= age_init();
                  flush_pend_q <= 1'b0;
               end else if (bus.proc_req) begin
                  req_q.tag  <= bus.address_from_proc[ADDR_W-1:OFF+IDX_W];
                  req_q.idx  <= bus.address_from_proc[OFF+IDX_W-1:OFF];
                  req_q.word <= bus.address_from_proc[OFF-1:2];
               end
            end
            LOOKUP: begin
               if (bus.flush) flush_pend_q <= 1'b1;
               if (any_hit) begin
                  data_q            <= line_q[req_q.idx][hit_way][req_q.word];
                  hit_miss_q        <= 1'b0;
                  resp_q            <= 1'b1;
                  age_q[req_q.idx]  <= age_nxt;
               end else begin
                  victim_q   <= victim;
                  ram_req_q  <= 1'b1;
                  ram_addr_q <= {req_q.tag, req_q.idx, OFF'(0)};
               end
            end
            REFILL: begin
               if (bus.flush) flush_pend_q <= 1'b1;
               if (bus.ram_access_done) begin
                  valid_q[req_q.idx][victim_q] <= 1'b1;
                  age_q[req_q.idx]             <= age_nxt;
                  ram_req_q                    <= 1'b0;
                  data_q                       <= ram_words[req_q.word];
                  hit_miss_q                   <= 1'b1;
                  resp_q                       <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and line storage need no reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (reset && state_q == REFILL && bus.ram_access_done) begin
         tag_q[req_q.idx][victim_q]  <= req_q.tag;
         line_q[req_q.idx][victim_q] <= ram_words;
      end
   end

   assign bus.data_to_proc    = data_q;
   assign bus.proc_resp_valid = resp_q;
   assign bus.hit_miss        = hit_miss_q;
   assign bus.busy            = (state_q != IDLE);
   assign bus.ram_req         = ram_req_q;
   assign bus.address_to_ram  = ram_addr_q;
endmodule

// File: tb/tb_icache_nway_lru.sv
// Randomized and directed bench for icache_nway_lru against a recency-stamp
// reference model (WAYS=4, SETS=4, WPL=2).
module tb_icache_nway_lru;
   localparam int WAYS = 4;
   localparam int SETS = 4;

   logic clk;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;

   icache_nway_lru_if #(.ADDR_W(32), .WPL(2)) bus ();

   icache_nway_lru #(.ADDR_W(32), .WAYS(WAYS), .SETS(SETS), .WPL(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: per set/way valid + line address, LRU by last-use stamp.
   bit          mv    [SETS][WAYS];
   logic [31:0] mla   [SETS][WAYS];
   int          stamp [SETS][WAYS];
   int          tick;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] ram_line(input logic [31:0] la);
      if (la == 32'h100) return 64'hAAAABBBB_11112222;
      return {la ^ 32'hC0DE0000, ~la};
   endfunction

   task automatic model_clear();
      tick = 0;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++) begin
            mv[s][w]    = 1'b0;
            stamp[s][w] = -w;
         end
   endtask

   task automatic chk_reset_outs();
      chk("rst_data", bus.data_to_proc, 0);
      chk("rst_resp", bus.proc_resp_valid, 0);
      chk("rst_hm", bus.hit_miss, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ram_req", bus.ram_req, 0);
      chk("rst_ram_addr", bus.address_to_ram, 0);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.proc_req = 1'b0;
      bus.flush = 1'b0;
      bus.ram_access_done = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_outs();
      reset = 1'b1;
      model_clear();
   endtask

   // One full fetch transaction, servicing the RAM port; returns observed hit_miss.
   task automatic access(input logic [31:0] a, input bit fl_refill, input bit tog,
                         output logic hm);
      logic [31:0] la, exp_d;
      logic [63:0] line;
      int s, hw, cyc, wait_n, best;
      bit exp_hit, got, saw;
      la = {a[31:3], 3'b000};
      s = int'(a[4:3]);
      exp_hit = 1'b0;
      hw = 0;
      for (int w = 0; w < WAYS; w++)
         if (mv[s][w] && mla[s][w] == la) begin exp_hit = 1'b1; hw = w; end
      line  = ram_line(la);
      exp_d = a[2] ? line[63:32] : line[31:0];
      bus.address_from_proc = a;
      bus.proc_req = 1'b1;
      cyc = 0; got = 1'b0; saw = 1'b0;
      wait_n = $urandom_range(0, 3);
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         bus.ram_access_done = 1'b0;
         bus.flush = 1'b0;
         bus.data_from_ram = {$urandom, $urandom};
         if (bus.proc_resp_valid) begin
            got = 1'b1;
            bus.proc_req = 1'b0;
         end else begin
            if (tog && cyc == 1) bus.proc_req = 1'b0;
            if (tog && cyc == 2) bus.proc_req = 1'b1;
            if (bus.ram_req) begin
               chk("ram_addr", bus.address_to_ram, la);
               if (!saw && fl_refill) bus.flush = 1'b1;
               saw = 1'b1;
               if (wait_n == 0) begin
                  bus.ram_access_done = 1'b1;
                  bus.data_from_ram = line;
               end else wait_n--;
            end
         end
      end
      bus.proc_req = 1'b0;
      hm = bus.hit_miss;
      chk("resp_seen", got, 1);
      chk("hit_miss", bus.hit_miss, !exp_hit);
      chk("data", bus.data_to_proc, exp_d);
      chk("ram_used", saw, !exp_hit);
      chk("ram_req_drop", bus.ram_req, 0);
      if (exp_hit) chk("hit_lat", cyc, 2);
      if (!exp_hit) begin
         hw = -1;
         for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) hw = w;
         if (hw < 0) begin
            best = stamp[s][0]; hw = 0;
            for (int w = 1; w < WAYS; w++)
               if (stamp[s][w] < best) begin best = stamp[s][w]; hw = w; end
         end
         mv[s][hw]  = 1'b1;
         mla[s][hw] = la;
      end
      tick++;
      stamp[s][hw] = tick;
      if (fl_refill && !exp_hit) model_clear();
      @(negedge clk);
      bus.ram_access_done = 1'b0;
      bus.flush = 1'b0;
      chk("resp_pulse", bus.proc_resp_valid, 0);
      chk("busy_idle", bus.busy, 0);
   endtask

   task automatic idle_flush();
      bus.proc_req = 1'b0;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("iflush_busy", bus.busy, 0);
      model_clear();
   endtask

   task automatic idle_noise();
      for (int k = 0; k < 3; k++) begin
         bus.ram_access_done = 1'b1;
         bus.data_from_ram = {$urandom, $urandom};
         @(negedge clk);
         chk("noise_resp", bus.proc_resp_valid, 0);
         chk("noise_ram_req", bus.ram_req, 0);
         chk("noise_busy", bus.busy, 0);
      end
      bus.ram_access_done = 1'b0;
   endtask

   initial begin
      logic hm;
      logic [31:0] a;
      int r, k;
      reset = 1'b0;
      bus.proc_req = 1'b0;
      bus.address_from_proc = '0;
      bus.flush = 1'b0;
      bus.data_from_ram = '0;
      bus.ram_access_done = 1'b0;
      do_reset();

      // cold miss then hits on the same line
      access(32'h104, 0, 0, hm);
      chk("cold_miss", hm, 1);
      chk("cold_data", bus.data_to_proc, 32'hAAAABBBB);
      access(32'h104, 0, 0, hm);
      chk("hit_a", hm, 0);
      access(32'h100, 0, 0, hm);
      chk("hit_b_data", bus.data_to_proc, 32'h11112222);

      // LRU eviction in set 0
      do_reset();
      access(32'h000, 0, 0, hm);
      access(32'h020, 0, 0, hm);
      access(32'h040, 0, 0, hm);
      access(32'h060, 0, 0, hm);
      access(32'h000, 0, 0, hm);
      access(32'h080, 0, 0, hm);
      chk("evict_miss", hm, 1);
      access(32'h000, 0, 0, hm); chk("keep_000", hm, 0);
      access(32'h040, 0, 0, hm); chk("keep_040", hm, 0);
      access(32'h060, 0, 0, hm); chk("keep_060", hm, 0);
      access(32'h020, 0, 0, hm); chk("gone_020", hm, 1);

      // flush during refill
      access(32'h104, 0, 0, hm);
      access(32'h1A0, 1, 0, hm);
      chk("flush_refill_resp", hm, 1);
      access(32'h104, 0, 0, hm);
      chk("flush_inval", hm, 1);

      // reset while refilling; late done is ignored
      bus.address_from_proc = 32'h2C8;
      bus.proc_req = 1'b1;
      k = 0;
      while (!bus.ram_req && k < 10) begin @(negedge clk); k++; end
      chk("mid_ram_req", bus.ram_req, 1);
      reset = 1'b0;
      bus.proc_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk_reset_outs();
      @(negedge clk);
      bus.ram_access_done = 1'b1;
      bus.data_from_ram = ram_line(32'h2C8);
      @(negedge clk);
      bus.ram_access_done = 1'b0;
      chk("late_done_resp", bus.proc_resp_valid, 0);
      chk("late_done_busy", bus.busy, 0);
      @(negedge clk);
      chk("late_done_resp2", bus.proc_resp_valid, 0);
      model_clear();
      access(32'h2C8, 0, 0, hm);
      chk("post_rst_miss", hm, 1);

      // spurious inputs
      idle_noise();
      access(32'h2CC, 0, 1, hm);
      chk("tog_hit", hm, 0);
      access(32'h3C8, 0, 1, hm);

      // flush and request together: request not taken that cycle
      bus.address_from_proc = 32'h2C8;
      bus.proc_req = 1'b1;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.proc_req = 1'b0;
      chk("flush_req_busy", bus.busy, 0);
      model_clear();
      access(32'h2C8, 0, 0, hm);
      chk("flush_req_miss", hm, 1);

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 24);
         a = ($urandom_range(0, 1) << 14) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
         if (r == 0)      idle_flush();
         else if (r == 1) idle_noise();
         else             access(a, r == 2, r == 3, hm);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end
endmodule
